// File: rtl/unified_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : unified_memory_arbiter                                          |
// | Purpose  : One word-addressed memory shared by NUM_PORTS requesters        |
// |            (port 0 = core data, port 1 = instruction fetch). A registered  |
// |            arbiter picks one request at a time and an access FSM           |
// |            (IDLE -> ACCESS -> WAIT* -> RESPOND) performs it. Each port     |
// |            sees a one-cycle gnt pulse when its request is captured and a   |
// |            one-cycle done pulse when the transaction completes.            |
// | Ports    : clk      - clock, rising edge                                   |
// |            reset    - asynchronous, active-low reset                       |
// |            req      - per-port request, held until gnt                     |
// |            we       - per-port write (1) / read (0)                        |
// |            byte_en  - per-port write byte enables, packed port-major       |
// |            addr     - per-port byte addresses, packed                      |
// |            wdata    - per-port write data, packed                          |
// |            gnt      - one-hot one-cycle pulse: request captured            |
// |            done     - one-hot one-cycle pulse: transaction complete        |
// |            rdata    - read data, valid with done of a read, else held      |
// | Config   : `define FIXED_PRIORITY_EN -> lowest-index requester always      |
// |            wins (round-robin pointer held at 0). Undefined -> round-robin. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module unified_memory_arbiter #(
  parameter int    NUM_PORTS         = 2,
  parameter int    BIT_COUNT         = 64,
  parameter int    ADDR_WIDTH        = 64,
  parameter int    MEMORY_SIZE_WORDS = 128,
  parameter int    READ_LATENCY      = 1,
  parameter string MEMORY_FILE_PATH  = ""
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             req,
  input  logic [NUM_PORTS-1:0]             we,
  input  logic [NUM_PORTS*BIT_COUNT/8-1:0] byte_en,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  addr,
  input  logic [NUM_PORTS*BIT_COUNT-1:0]   wdata,
  output logic [NUM_PORTS-1:0]             gnt,
  output logic [NUM_PORTS-1:0]             done,
  output logic [BIT_COUNT-1:0]             rdata
);

  localparam int c_BYTES  = BIT_COUNT / 8;
  localparam int c_OFF_W  = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;
  localparam int c_PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_MA_W   = (MEMORY_SIZE_WORDS > 1) ? $clog2(MEMORY_SIZE_WORDS) : 1;
  localparam int c_CNT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;

  localparam logic [ADDR_WIDTH-1:0] c_MEM_WORDS = ADDR_WIDTH'(MEMORY_SIZE_WORDS);
  localparam logic [c_CNT_W-1:0]    c_WAIT_LAST = c_CNT_W'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam logic [NUM_PORTS-1:0]  c_ONE       = NUM_PORTS'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [BIT_COUNT-1:0]  r_mem [0:MEMORY_SIZE_WORDS-1];

  logic [c_PORT_W-1:0]   r_rrPtr;
  logic [c_PORT_W-1:0]   r_winner;
  logic                  r_we;
  logic [c_BYTES-1:0]    r_byteEn;
  logic [BIT_COUNT-1:0]  r_wdata;
  logic [c_MA_W-1:0]     r_memAddr;
  logic                  r_inRange;
  logic [c_CNT_W-1:0]    r_waitCnt;
  logic [BIT_COUNT-1:0]  r_readData;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [NUM_PORTS-1:0]  r_done;
  logic [BIT_COUNT-1:0]  r_rdata;

  logic                  w_anyReq;
  logic [c_PORT_W-1:0]   w_winner;
  logic [ADDR_WIDTH-1:0] w_selAddr;
  logic [ADDR_WIDTH-1:0] w_wordIdx;
  logic [BIT_COUNT-1:0]  w_memWord;
`ifndef FIXED_PRIORITY_EN
  logic                  w_found;
`endif

  // Winner selection: scan from the round-robin pointer (or from port 0).
  always_comb begin
    w_anyReq = |req;
    w_winner = '0;
`ifdef FIXED_PRIORITY_EN
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (req[k]) w_winner = c_PORT_W'(k);
    end
`else
    w_found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_found && req[c_PORT_W'((int'(r_rrPtr) + k) % NUM_PORTS)]) begin
        w_winner = c_PORT_W'((int'(r_rrPtr) + k) % NUM_PORTS);
        w_found  = 1'b1;
      end
    end
`endif
  end

  // Offset bits are shifted away; the full remaining index is range-checked
  // so high address bits cannot alias onto low words.
  assign w_selAddr = addr[int'(w_winner) * ADDR_WIDTH +: ADDR_WIDTH];
  assign w_wordIdx = w_selAddr >> c_OFF_W;
  assign w_memWord = r_inRange ? r_mem[r_memAddr] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:    if (w_anyReq) w_nextState = S_ACCESS;
      S_ACCESS:  w_nextState = (r_we || READ_LATENCY == 1) ? S_RESPOND : S_WAIT;
      S_WAIT:    if (r_waitCnt == c_WAIT_LAST) w_nextState = S_RESPOND;
      S_RESPOND: w_nextState = S_IDLE;
      default:   w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rrPtr    <= '0;
      r_winner   <= '0;
      r_we       <= 1'b0;
      r_byteEn   <= '0;
      r_wdata    <= '0;
      r_memAddr  <= '0;
      r_inRange  <= 1'b0;
      r_waitCnt  <= '0;
      r_readData <= '0;
      r_gnt      <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_anyReq) begin
            r_winner  <= w_winner;
            r_we      <= we[w_winner];
            r_byteEn  <= byte_en[int'(w_winner) * c_BYTES +: c_BYTES];
            r_wdata   <= wdata[int'(w_winner) * BIT_COUNT +: BIT_COUNT];
            r_memAddr <= w_wordIdx[c_MA_W-1:0];
            r_inRange <= (w_wordIdx < c_MEM_WORDS);
            r_gnt     <= c_ONE << w_winner;
`ifndef FIXED_PRIORITY_EN
            r_rrPtr   <= c_PORT_W'((int'(w_winner) + 1) % NUM_PORTS);
`endif
          end
        end
        S_ACCESS: begin
          r_waitCnt  <= '0;
          r_readData <= w_memWord;
          if (w_nextState == S_RESPOND) begin
            r_done <= c_ONE << r_winner;
            if (!r_we) r_rdata <= w_memWord;
          end
        end
        S_WAIT: begin
          r_waitCnt <= r_waitCnt + c_CNT_W'(1);
          if (w_nextState == S_RESPOND) begin
            r_done  <= c_ONE << r_winner;
            r_rdata <= r_readData;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage has no reset. Reset forces r_state to IDLE asynchronously, so an
  // abandoned transaction can never reach the write below.
  always_ff @(posedge clk) begin
    if (r_state == S_ACCESS && r_we && r_inRange) begin
      for (int b = 0; b < c_BYTES; b++) begin
        if (r_byteEn[b]) r_mem[r_memAddr][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign gnt   = r_gnt;
  assign done  = r_done;
  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_unified_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_unified_memory_arbiter                                       |
// | Purpose  : Directed bench for unified_memory_arbiter. Instance 0 uses      |
// |            READ_LATENCY=1, instance 1 uses READ_LATENCY=3.                 |
// | Ports    : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_unified_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]   reqA   [2];
  logic [1:0]   weA    [2];
  logic [15:0]  beA    [2];
  logic [127:0] addrA  [2];
  logic [127:0] wdataA [2];
  logic [1:0]   gntA   [2];
  logic [1:0]   doneA  [2];
  logic [63:0]  rdataA [2];

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  unified_memory_arbiter #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req(reqA[0]), .we(weA[0]), .byte_en(beA[0]),
    .addr(addrA[0]), .wdata(wdataA[0]), .gnt(gntA[0]), .done(doneA[0]), .rdata(rdataA[0])
  );

  unified_memory_arbiter #(.READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req(reqA[1]), .we(weA[1]), .byte_en(beA[1]),
    .addr(addrA[1]), .wdata(wdataA[1]), .gnt(gntA[1]), .done(doneA[1]), .rdata(rdataA[1])
  );

  typedef struct {
    int          port;
    bit          wr;
    logic [7:0]  be;
    logic [63:0] a;
    logic [63:0] wd;
    logic [63:0] expRd;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One single-port transaction; cycle 1 = first negedge after req is sampled.
  task automatic doTxn(input int sel, input int port, input bit wr, input logic [7:0] be,
                       input logic [63:0] a, input logic [63:0] wd, input logic [63:0] expRd,
                       input int expDone, input string nm);
    int cyc;
    bit seen;
    @(negedge clk);
    chk({nm, " idle gnt"}, 64'(gntA[sel]), 64'd0);
    chk({nm, " idle done"}, 64'(doneA[sel]), 64'd0);
    weA[sel][port]               = wr;
    beA[sel][port*8 +: 8]        = be;
    addrA[sel][port*64 +: 64]    = a;
    wdataA[sel][port*64 +: 64]   = wd;
    reqA[sel][port]              = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gntA[sel] != 2'b00) seen = 1'b1;
    end
    reqA[sel] = 2'b00;
    chk({nm, " gnt"}, 64'(gntA[sel]), 64'(2'b01 << port));
    chk({nm, " gnt cycle"}, 64'(cyc), 64'd1);
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (doneA[sel] != 2'b00) seen = 1'b1;
    end
    chk({nm, " done"}, 64'(doneA[sel]), 64'(2'b01 << port));
    chk({nm, " done cycle"}, 64'(cyc), 64'(expDone));
    chk({nm, " rdata"}, rdataA[sel], expRd);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cyc;
    int  nG;
    int  nD;
    int  lastW;
    int  expW;
    bit  seen;

    vecs[0]  = '{0, 1'b1, 8'hFF, 64'h10,  64'h1122334455667788, 64'h0};
    vecs[1]  = '{0, 1'b0, 8'h00, 64'h10,  64'h0,                64'h1122334455667788};
    vecs[2]  = '{1, 1'b1, 8'h0F, 64'h10,  64'hAAAAAAAAAAAAAAAA, 64'h1122334455667788};
    vecs[3]  = '{1, 1'b0, 8'h00, 64'h10,  64'h0,                64'h11223344AAAAAAAA};
    vecs[4]  = '{0, 1'b1, 8'hFF, 64'h1F,  64'h0123456789ABCDEF, 64'h11223344AAAAAAAA};
    vecs[5]  = '{1, 1'b0, 8'h00, 64'h18,  64'h0,                64'h0123456789ABCDEF};
    vecs[6]  = '{1, 1'b1, 8'h81, 64'h18,  64'hFFEEDDCCBBAA9988, 64'h0123456789ABCDEF};
    vecs[7]  = '{0, 1'b0, 8'h00, 64'h1B,  64'h0,                64'hFF23456789ABCD88};
    vecs[8]  = '{0, 1'b1, 8'hFF, 64'h3F8, 64'h5A5A5A5A5A5A5A5A, 64'hFF23456789ABCD88};
    vecs[9]  = '{1, 1'b0, 8'h00, 64'h3FF, 64'h0,                64'h5A5A5A5A5A5A5A5A};
    vecs[10] = '{1, 1'b1, 8'hFF, 64'h400, 64'h1234567812345678, 64'h5A5A5A5A5A5A5A5A};
    vecs[11] = '{0, 1'b0, 8'h00, 64'h400, 64'h0,                64'h0};
    vecs[12] = '{0, 1'b0, 8'h00, 64'h0,   64'h0,                64'h0F0F0F0F0F0F0F0F};
    vecs[13] = '{0, 1'b0, 8'h00, 64'h10,  64'h0,                64'h11223344AAAAAAAA};
    vecs[14] = '{1, 1'b0, 8'h00, 64'h8000000000000010, 64'h0,   64'h0};

    for (int s = 0; s < 2; s++) begin
      reqA[s] = '0; weA[s] = '0; beA[s] = '0; addrA[s] = '0; wdataA[s] = '0;
    end

    // Reset held with both ports requesting writes: nothing may respond.
    reset     = 1'b0;
    reqA[0]   = 2'b11;
    weA[0]    = 2'b11;
    beA[0]    = 16'hFFFF;
    addrA[0]  = {64'h8, 64'h0};
    wdataA[0] = {64'hDEADBEEFDEADBEEF, 64'h0F0F0F0F0F0F0F0F};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset gnt",   64'(gntA[0]),  64'd0);
      chk("reset done",  64'(doneA[0]), 64'd0);
      chk("reset rdata", rdataA[0],     64'd0);
      chk("reset rdata l3", rdataA[1],  64'd0);
    end
    reset = 1'b1;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (gntA[0] != 2'b00) seen = 1'b1;
    end
    reqA[0] = 2'b00;
    chk("post-reset first gnt", 64'(gntA[0]), 64'h1);
    chk("post-reset gnt cycle", 64'(cyc), 64'd1);
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (doneA[0] != 2'b00) seen = 1'b1;
    end
    chk("post-reset write done", 64'(doneA[0]), 64'h1);
    chk("post-reset done cycle", 64'(cyc), 64'd2);
    chk("post-reset write rdata", rdataA[0], 64'd0);

    // Table of single-port transactions on the latency-1 instance.
    for (int i = 0; i < 15; i++) begin
      doTxn(0, vecs[i].port, vecs[i].wr, vecs[i].be, vecs[i].a, vecs[i].wd,
            vecs[i].expRd, 2, $sformatf("vec%0d", i));
    end

    // Both ports held requesting: four back-to-back reads.
    @(negedge clk);
    weA[0]   = 2'b00;
    addrA[0] = {64'h18, 64'h10};
    reqA[0]  = 2'b11;
    cyc = 0; nG = 0; nD = 0; lastW = 0;
    while (nD < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      chk("arb no double gnt", 64'(gntA[0] == 2'b11), 64'd0);
      if (gntA[0] != 2'b00) begin
`ifdef FIXED_PRIORITY_EN
        expW = 0;
`else
        expW = nG % 2;
`endif
        chk($sformatf("arb gnt%0d", nG), 64'(gntA[0]), 64'(2'b01 << expW));
        chk($sformatf("arb gnt%0d cycle", nG), 64'(cyc), 64'(1 + 3*nG));
        lastW = (gntA[0] == 2'b10) ? 1 : 0;
        nG++;
        if (nG == 4) reqA[0] = 2'b00;
      end
      if (doneA[0] != 2'b00) begin
        chk($sformatf("arb done%0d", nD), 64'(doneA[0]), 64'(2'b01 << lastW));
        chk($sformatf("arb rdata%0d", nD), rdataA[0],
            (lastW == 1) ? 64'hFF23456789ABCD88 : 64'h11223344AAAAAAAA);
        nD++;
      end
    end
    chk("arb grant count", 64'(nG), 64'd4);
    chk("arb done count",  64'(nD), 64'd4);

    // Latency-3 instance: timing and out-of-range read.
    doTxn(1, 0, 1'b1, 8'hFF, 64'h20,  64'hCAFEBABE00112233, 64'h0, 2, "l3 write");
    doTxn(1, 1, 1'b0, 8'h00, 64'h20,  64'h0, 64'hCAFEBABE00112233, 4, "l3 read");
    doTxn(1, 0, 1'b0, 8'h00, 64'h400, 64'h0, 64'h0,                4, "l3 oor read");

    // Reset during the WAIT phase of a latency-3 read.
    @(negedge clk);
    weA[1]   = 2'b00;
    addrA[1] = {64'h0, 64'h20};
    reqA[1]  = 2'b01;
    @(negedge clk);
    reqA[1] = 2'b00;
    chk("rstwait gnt", 64'(gntA[1]), 64'h1);
    @(negedge clk);
    chk("rstwait pre done", 64'(doneA[1]), 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rstwait done",  64'(doneA[1]), 64'd0);
      chk("rstwait rdata", rdataA[1],     64'd0);
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abandoned no done", 64'(doneA[1]), 64'd0);
    end
    doTxn(1, 0, 1'b0, 8'h00, 64'h20, 64'h0, 64'hCAFEBABE00112233, 4, "l3 after reset");
    doTxn(0, 1, 1'b0, 8'h00, 64'h10, 64'h0, 64'h11223344AAAAAAAA, 2, "l1 after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
